// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter and its requesters.
package mem_arbiter_pkg;

  localparam int MEM_AW = 5;
  localparam int MEM_DW = 16;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e grant_of(input logic id);
    return (id == REQ_ID1) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return tracker: READ_LAT-deep valid/id shift register aligned with memory read latency.
module mem_rd_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_issue,
  input  logic       i_id,
  output logic [1:0] o_rvalid,
  output logic       o_pending
);

  logic [READ_LAT-1:0] r_vld;
  logic [READ_LAT-1:0] r_id;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= i_issue;
      r_id[0]  <= i_id;
      for (int k = 1; k < READ_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
    end
  end

  // Masked during reset so a return landing in the reset cycle is dropped too.
  always_comb begin
    o_rvalid          = 2'b00;
    o_rvalid[REQ_ID0] = r_vld[READ_LAT-1] & (r_id[READ_LAT-1] == REQ_ID0) & ~i_reset;
    o_rvalid[REQ_ID1] = r_vld[READ_LAT-1] & (r_id[READ_LAT-1] == REQ_ID1) & ~i_reset;
    o_pending         = |r_vld;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the single-port word memory, with burst limit and lock.
//   state  | meaning
//   IDLE   | no grant held
//   GRANT0 | requester 0 owns the memory port
//   GRANT1 | requester 1 owns the memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = MEM_AW,
  parameter int DW        = MEM_DW,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_lock,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_addr_in0,
  input  logic [AW-1:0] i_addr_in1,
  input  logic [DW-1:0] i_wdata_in0,
  input  logic [DW-1:0] i_wdata_in1,
  output logic [1:0]    o_gnt,
  output logic [DW-1:0] o_rdata,
  output logic [1:0]    o_rvalid,
  output logic [AW-1:0] o_address,
  output logic [DW-1:0] o_data_in,
  input  logic [DW-1:0] i_data_out,
  output logic          o_read_enable,
  output logic          o_write_enable,
  output logic          o_busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          r_prio;
  logic [BW-1:0] r_burst;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;

  logic          w_cur;
  logic          w_oth;
  logic          w_granted;
  logic          w_issue;
  logic          w_cur_we;
  logic          w_switch;
  logic [AW-1:0] w_cur_addr;
  logic [DW-1:0] w_cur_wdata;
  logic          w_rd_pending;

  always_comb begin
    w_cur       = (r_state == GRANT1);
    w_oth       = ~w_cur;
    w_granted   = (r_state != IDLE);
    w_issue     = w_granted & i_req[w_cur];
    w_cur_we    = i_we[w_cur];
    w_cur_addr  = w_cur ? i_addr_in1 : i_addr_in0;
    w_cur_wdata = w_cur ? i_wdata_in1 : i_wdata_in0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_req == 2'b11)
          w_state_nxt = grant_of(r_prio);
        else if (i_req[0])
          w_state_nxt = GRANT0;
        else if (i_req[1])
          w_state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        // A held lock pins the grant even when the owner is momentarily not requesting.
        if (!i_lock[w_cur]) begin
          if (!i_req[w_cur])
            w_state_nxt = i_req[w_oth] ? grant_of(w_oth) : IDLE;
          else if ((r_burst == BURST_LAST) && i_req[w_oth])
            w_state_nxt = grant_of(w_oth);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_switch = (w_state_nxt != r_state);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_prio  <= REQ_ID0;
      r_burst <= '0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_granted && w_switch)
        r_prio <= w_oth;
      if (w_switch || !w_granted)
        r_burst <= '0;
      else if (w_issue && (r_burst != BURST_LAST))
        r_burst <= r_burst + BW'(1);
      if (w_issue) begin
        r_addr <= w_cur_addr;
        r_din  <= w_cur_wdata;
      end
    end
  end

  mem_rd_pipe #(
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_issue   (o_read_enable),
    .i_id      (w_cur),
    .o_rvalid  (o_rvalid),
    .o_pending (w_rd_pending)
  );

  always_comb begin
    o_gnt          = {r_state == GRANT1, r_state == GRANT0};
    o_read_enable  = w_issue & ~w_cur_we;
    o_write_enable = w_issue & w_cur_we;
    o_address      = w_issue ? w_cur_addr : r_addr;
    o_data_in      = w_issue ? w_cur_wdata : r_din;
    o_rdata        = i_data_out;
    o_busy         = w_granted | w_rd_pending;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32x16 memory behind it.
module tb_mem_arbiter;

  localparam int AW        = 5;
  localparam int DW        = 16;
  localparam int READ_LAT  = 1;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata, data_in, data_out;
  logic [AW-1:0] address;
  logic          re, wr, busy;

  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] rd_pipe [0:READ_LAT-1];

  int n_cmp = 0;
  int n_bad = 0;
  int n_re0 = 0;
  int n_we = 0;
  int n_rv = 0;
  int n_rv1 = 0;
  int lock_idle [2] = '{0, 0};
  int lock_idle_max = 0;
  logic [DW-1:0] rv0_q [$];
  int s_re0, s_we, s_rv, s_rv1;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .READ_LAT(READ_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req          (req),
    .i_lock         (lock),
    .i_we           (we),
    .i_addr_in0     (addr0),
    .i_addr_in1     (addr1),
    .i_wdata_in0    (wdata0),
    .i_wdata_in1    (wdata1),
    .o_gnt          (gnt),
    .o_rdata        (rdata),
    .o_rvalid       (rvalid),
    .o_address      (address),
    .o_data_in      (data_in),
    .i_data_out     (data_out),
    .o_read_enable  (re),
    .o_write_enable (wr),
    .o_busy         (busy)
  );

  always @(posedge clk) begin
    if (wr) mem[address] <= data_in;
    if (re) rd_pipe[0] <= mem[address];
    for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign data_out = rd_pipe[READ_LAT-1];

  always @(negedge clk) begin
    if (re && gnt == 2'b01) n_re0++;
    if (wr) n_we++;
    if (rvalid != 2'b00) n_rv++;
    if (rvalid[0]) rv0_q.push_back(rdata);
    if (rvalid[1]) n_rv1++;
    for (int r = 0; r < 2; r++) begin
      if (lock[r] && !req[r]) lock_idle[r]++;
      else lock_idle[r] = 0;
      if (lock_idle[r] > lock_idle_max) lock_idle_max = lock_idle[r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int k = 0; k < READ_LAT; k++) rd_pipe[k] = '0;
    mem[5]  = 16'h1234;
    mem[31] = 16'h00FF;
    for (int i = 0; i < 8; i++) mem[8+i] = 16'hA000 + 16'(i);

    // 1: single read from requester 0
    do_reset();
    settle();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_en", {re, wr}, 2'b00);
    req = 2'b01; addr0 = 5; tick();
    settle();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_re", re, 1'b1);
    chk("t1_addr", address, 5);
    tick();
    req = 2'b00;
    settle();
    chk("t1_rvalid", rvalid, 2'b01);
    chk("t1_rdata", rdata, 16'h1234);
    tick();
    settle();
    chk("t1_idle_gnt", gnt, 2'b00);
    chk("t1_idle_busy", busy, 1'b0);
    tick();

    // 2: simultaneous requests and pointer rotation
    do_reset();
    req = 2'b11; addr0 = 1; addr1 = 2; tick();
    settle();
    chk("t2_first", gnt, 2'b01);
    tick();
    req = 2'b10;
    settle();
    chk("t2_hold0", gnt, 2'b01);
    tick();
    settle();
    chk("t2_direct1", gnt, 2'b10);
    tick();
    req = 2'b00; tick();
    settle();
    chk("t2_idle", gnt, 2'b00);
    req = 2'b11; tick();
    settle();
    chk("t2_after_rel1", gnt, 2'b01);
    req = 2'b00; tick();
    req = 2'b11; tick();
    settle();
    chk("t2_after_rel0", gnt, 2'b10);
    req = 2'b00; tick(); tick();

    // 3: burst limit forces a switch after MAX_BURST reads
    do_reset();
    rv0_q.delete();
    s_re0 = n_re0;
    req = 2'b11; we = 2'b00; addr0 = 8; addr1 = 20; tick();
    for (int i = 0; i < MAX_BURST; i++) begin
      addr0 = AW'(8 + i);
      settle();
      chk("t3_gnt0", gnt, 2'b01);
      tick();
    end
    settle();
    chk("t3_switch", gnt, 2'b10);
    tick();
    req = 2'b00;
    repeat (READ_LAT + 2) tick();
    chk("t3_re_count", n_re0 - s_re0, MAX_BURST);
    chk("t3_rv0_count", rv0_q.size(), MAX_BURST);
    for (int i = 0; i < MAX_BURST && i < rv0_q.size(); i++)
      chk("t3_rv0_data", rv0_q[i], 16'hA000 + 16'(i));

    // 4: locked read-modify-write by requester 1 at address 31
    req = 2'b10; lock = 2'b10; we = 2'b00; addr1 = 31; addr0 = 9; tick();
    req = 2'b11;
    settle();
    chk("t4_gnt_rd", gnt, 2'b10);
    chk("t4_re", re, 1'b1);
    chk("t4_addr", address, 31);
    tick();
    req = 2'b01;
    settle();
    chk("t4_gnt_nreq", gnt, 2'b10);
    chk("t4_rvalid", rvalid, 2'b10);
    chk("t4_rdata", rdata, 16'h00FF);
    tick();
    req = 2'b11; we = 2'b10; wdata1 = 16'h0100;
    settle();
    chk("t4_gnt_wr", gnt, 2'b10);
    chk("t4_we", wr, 1'b1);
    tick();
    req = 2'b01; lock = 2'b00; we = 2'b00;
    settle();
    chk("t4_gnt_unlock", gnt, 2'b10);
    tick();
    settle();
    chk("t4_gnt0", gnt, 2'b01);
    chk("t4_mem31", mem[31], 16'h0100);
    tick();
    req = 2'b00; tick(); tick();

    // 5: reset right after a read issue
    do_reset();
    req = 2'b01; addr0 = 3; tick();
    settle();
    chk("t5_re", re, 1'b1);
    tick();
    s_rv = n_rv;
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 2'b00;
    settle();
    chk("t5_gnt", gnt, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_en", {re, wr}, 2'b00);
    repeat (READ_LAT + 2) tick();
    chk("t5_no_rvalid", n_rv - s_rv, 0);

    // 6: write from requester 1, read back by requester 0
    do_reset();
    rv0_q.delete();
    s_we = n_we; s_rv1 = n_rv1;
    req = 2'b10; we = 2'b10; addr1 = 0; wdata1 = 16'hBEEF; tick();
    settle();
    chk("t6_we", wr, 1'b1);
    chk("t6_din", data_in, 16'hBEEF);
    tick();
    req = 2'b01; we = 2'b00; addr0 = 0; tick();
    settle();
    chk("t6_gnt0", gnt, 2'b01);
    chk("t6_re", re, 1'b1);
    tick();
    req = 2'b00;
    settle();
    chk("t6_rvalid", rvalid, 2'b01);
    chk("t6_rdata", rdata, 16'hBEEF);
    tick(); tick();
    chk("t6_we_count", n_we - s_we, 1);
    chk("t6_no_rv1", n_rv1 - s_rv1, 0);

    chk("lock_rule", lock_idle_max > 16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
